// File: rtl/flag_pkg.sv
// Shared constants for the flag unit: branch condition codes, FSM states, flag bit positions.
package flag_pkg;

  localparam int COND_W = 3;

  localparam logic [COND_W-1:0] C_BEQ  = 3'b000;
  localparam logic [COND_W-1:0] C_BNE  = 3'b001;
  localparam logic [COND_W-1:0] C_BLT  = 3'b100;
  localparam logic [COND_W-1:0] C_BGE  = 3'b101;
  localparam logic [COND_W-1:0] C_BLTU = 3'b110;
  localparam logic [COND_W-1:0] C_BGEU = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    RUN = 1'b0,
    IRQ = 1'b1
  } state_t;

endpackage

// File: rtl/flag_unit_cond_eval.sv
// Combinational branch-condition evaluator over {N,Z,C,V}; reserved codes resolve to not-taken.
module cond_eval
  import flag_pkg::*;
#(
  parameter int COND_W = flag_pkg::COND_W
) (
  input  logic [3:0]        i_flags,
  input  logic [COND_W-1:0] i_cond,
  output logic              o_taken
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      C_BEQ:   o_taken = w_z;
      C_BNE:   o_taken = ~w_z;
      C_BLT:   o_taken = w_n ^ w_v;
      C_BGE:   o_taken = ~(w_n ^ w_v);
      C_BLTU:  o_taken = w_c;
      C_BGEU:  o_taken = ~w_c;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Flag register with single-level IRQ save/restore and a one-cycle registered branch resolver.
// Committed and bypassed ALU flags both feed the condition check; stall freezes all state.
module flag_unit
  import flag_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter int          COND_W   = flag_pkg::COND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              flag_we,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [COND_W-1:0] br_cond,
  input  logic              irq_enter,
  input  logic              irq_return,
  output logic [3:0]        flags_q,
  output logic              br_taken,
  output logic              br_done,
  output logic              in_irq,
  output logic              irq_err
);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_flags, r_shadow;
  logic [3:0] w_flags_nxt, w_shadow_nxt;
  logic [3:0] w_alu, w_eff;
  logic       w_taken, w_err_nxt;
  logic       r_br_taken, r_br_done, r_irq_err;

  assign w_alu = {alu_n, alu_z, alu_c, alu_v};
  assign w_eff = flag_we ? w_alu : r_flags;

  cond_eval #(.COND_W(COND_W)) u_cond_eval (
    .i_flags (w_eff),
    .i_cond  (br_cond),
    .o_taken (w_taken)
  );

  // A restore overrides any same-cycle commit; the shadow captures the bypassed flags on entry.
  always_comb begin
    w_state_nxt  = r_state;
    w_flags_nxt  = w_eff;
    w_shadow_nxt = r_shadow;
    w_err_nxt    = 1'b0;
    case (r_state)
      RUN: begin
        if (irq_enter) begin
          w_shadow_nxt = w_eff;
          w_state_nxt  = IRQ;
        end else if (irq_return) begin
          w_err_nxt = 1'b1;
        end
      end
      IRQ: begin
        if (irq_return) begin
          w_flags_nxt = r_shadow;
          w_state_nxt = RUN;
        end else if (irq_enter) begin
          w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_flags    <= FLAG_RST;
      r_shadow   <= FLAG_RST;
      r_br_taken <= 1'b0;
      r_br_done  <= 1'b0;
      r_irq_err  <= 1'b0;
    end else if (!stall) begin
      r_state   <= w_state_nxt;
      r_flags   <= w_flags_nxt;
      r_shadow  <= w_shadow_nxt;
      r_br_done <= br_valid;
      r_irq_err <= w_err_nxt;
      if (br_valid) begin
        r_br_taken <= w_taken;
      end
    end else begin
      r_br_done <= 1'b0;
      r_irq_err <= 1'b0;
    end
  end

  assign flags_q  = r_flags;
  assign br_taken = r_br_taken;
  assign br_done  = r_br_done;
  assign in_irq   = (r_state == IRQ);
  assign irq_err  = r_irq_err;

endmodule

// File: doc/flag_unit.md
# flag_unit

Status-flag register and branch-condition evaluator that consumes the N/Z/C/V flags produced by the 32-bit ALU. It commits ALU flags on request, saves and restores them across interrupt entry and return (single level, no nesting), and resolves conditional branches against the current flags with one-cycle registered latency. It sits between the execute-stage ALU and the fetch/PC control logic.

## Interface
- FLAG_RST, 4'b0000: reset/initial value of the flag register, ordered {N,Z,C,V}
- COND_W, 3: width of the branch condition code (RV32 funct3)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- alu_n, alu_z, alu_c, alu_v  in  1 each  flags from the ALU for the current instruction
- flag_we  in  1  commit the ALU flags at this edge
- stall  in  1  freeze: no register updates this cycle
- br_valid  in  1  branch request this cycle
- br_cond  in  COND_W  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 reserved
- irq_enter  in  1  single-cycle interrupt-entry pulse
- irq_return  in  1  single-cycle return-from-interrupt pulse
- flags_q  out  4  committed flags {N,Z,C,V}
- br_taken  out  1  registered branch decision
- br_done  out  1  one-cycle pulse: br_taken is valid
- in_irq  out  1  high while in the IRQ state
- irq_err  out  1  one-cycle pulse on an illegal irq_enter/irq_return

## Operation
- FSM states: RUN and IRQ. Reset → RUN.
- Effective flags `eff` = ALU flags when flag_we=1, else flags_q (same-cycle bypass).
- Condition evaluation on `eff`: BEQ=Z, BNE=!Z, BLT=N^V, BGE=!(N^V), BLTU=C, BGEU=!C. Reserved codes evaluate to not-taken and pulse irq_err=0 (no error). They are simply not-taken.
- RUN + irq_enter: shadow ← `eff`; go to IRQ. flag_we still commits to flags_q in the same cycle.
- IRQ + irq_return: flags_q ← shadow; go to RUN. A simultaneous flag_we is discarded because the restore wins.
- IRQ + irq_enter (nesting) or RUN + irq_return: ignored, with an irq_err pulse the next cycle.
- irq_enter and irq_return together: in RUN, enter wins. In IRQ, return wins. Neither case sets irq_err.
- Branches are legal in both states. br_valid is independent of IRQ events. The evaluation uses `eff` before any restore takes effect in that cycle.
- stall=1: flags_q, shadow, FSM state and br_taken hold. br_done and irq_err are forced to 0. Sources must hold their requests until stall drops.

## Timing
- Reset (rst_n=0 at edge): flags_q=FLAG_RST, shadow=FLAG_RST, state=RUN. br_taken=0, br_done=0, in_irq=0, irq_err=0. Reset overrides every other input, including mid-IRQ.
- flags_q updates at the edge where flag_we=1 and stall=0. Visible the next cycle.
- br_valid at cycle t (no stall) → br_done=1 and br_taken valid at t+1. br_taken holds until the next completed branch.
- Back-to-back br_valid gives one result per cycle.
- in_irq rises the cycle after irq_enter and falls the cycle after irq_return.
- Latency from a restore to the new flags_q value is 1 cycle.

## Structure
- Package flag_pkg holds:
  - condition-code constants (BEQ..BGEU)
  - state enum {RUN, IRQ}
  - flag bit indices (N=3, Z=2, C=1, V=0)
- Sub-module cond_eval: purely combinational, (flags[3:0], cond[COND_W-1:0]) → taken. It is reused by any future compare-and-branch path.
- Top-level: flag register, shadow register, 2-state FSM, output registers. Target size is 150–250 lines.

## Test plan
- Reset, then flag_we with N,Z,C,V=0,1,0,0 → flags_q=4'b0100 next cycle. br_valid BEQ → br_done=1, br_taken=1 one cycle later.
- Bypass: flags_q=0000; same cycle flag_we with Z=1 and br_valid BNE → br_taken=0. BLT with N=1,V=0 → taken=1. BGEU with C=1 → taken=0.
- Save/restore: flags_q=1010, irq_enter → in_irq=1. Then flag_we 0101 → flags_q=0101. Then irq_return with flag_we 1111 → flags_q=1010, in_irq=0.
- Illegal events: irq_return in RUN → irq_err pulse, state unchanged. irq_enter while in IRQ → irq_err pulse, shadow unchanged. Simultaneous enter+return in RUN → enters IRQ, irq_err=0.
- Stall: stall=1 with flag_we, br_valid and irq_enter asserted → no change, br_done=0. Release stall → all three take effect at the next edge.
- Reset mid-IRQ: in IRQ with shadow=1100, assert rst_n=0 → flags_q=0000, in_irq=0. A subsequent irq_return → irq_err pulse.
